// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: walks a one-hot row strobe at a prescaled tick rate,
// debounces press and release on the column lines and reports a binary keycode.
module keypad_scan_debounce #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int DIV_W    = 16,
  parameter int DEBOUNCE = 3,
  localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              fin,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [COLS-1:0]   colum,
  output logic [ROWS-1:0]   scan,
  output logic [CODE_W-1:0] keycode,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int DEB_W   = $clog2(DEBOUNCE + 1);
  localparam bit DEB_ONE = (DEBOUNCE == 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEB_PRESS, ST_HELD, ST_DEB_REL} state_t;

  logic [DIV_W-1:0]  presc_r;
  logic              tick_s;
  state_t            state_r, state_s;
  logic [ROW_W-1:0]  row_r, row_s;
  logic [COLS-1:0]   col_r, col_s;
  logic [DEB_W-1:0]  deb_r, deb_s;
  logic [CODE_W-1:0] keycode_r, keycode_s;
  logic              valid_r, valid_s;
  logic              held_r, held_s;
  logic              merr_r, merr_s;

  function automatic logic is_onehot(input logic [COLS-1:0] c);
    return (c != '0) && ((c & (c - COLS'(1))) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] col_index(input logic [COLS-1:0] c);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (c[i]) idx = CODE_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? '0 : r + ROW_W'(1);
  endfunction

  function automatic logic [CODE_W-1:0] make_code(input logic [COLS-1:0] c,
                                                  input logic [ROW_W-1:0] r);
    return col_index(c) * CODE_W'(ROWS) + CODE_W'(r);
  endfunction

  assign tick_s    = enable & (&presc_r);
  assign scan      = ROWS'(1) << row_r;
  assign keycode   = keycode_r;
  assign key_valid = valid_r;
  assign key_held  = held_r;
  assign multi_err = merr_r;

  // Scan-rate prescaler, held at zero while disabled.
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n)       presc_r <= '0;
    else if (!enable) presc_r <= '0;
    else              presc_r <= presc_r + DIV_W'(1);
  end

  // Next-state and output decode; state only moves on a scan tick.
  always_comb begin
    state_s   = state_r;
    row_s     = row_r;
    col_s     = col_r;
    deb_s     = deb_r;
    keycode_s = keycode_r;
    held_s    = held_r;
    valid_s   = 1'b0;
    merr_s    = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (colum == '0) begin
            row_s = next_row(row_r);
          end else if (is_onehot(colum)) begin
            col_s = colum;
            if (DEB_ONE) begin
              keycode_s = make_code(colum, row_r);
              valid_s   = 1'b1;
              held_s    = 1'b1;
              deb_s     = '0;
              state_s   = ST_HELD;
            end else begin
              deb_s   = DEB_W'(1);
              state_s = ST_DEB_PRESS;
            end
          end else begin
            merr_s = 1'b1;
          end
        end
        ST_DEB_PRESS: begin
          if (colum == col_r) begin
            if (deb_r + DEB_W'(1) == DEB_W'(DEBOUNCE)) begin
              keycode_s = make_code(col_r, row_r);
              valid_s   = 1'b1;
              held_s    = 1'b1;
              deb_s     = '0;
              state_s   = ST_HELD;
            end else begin
              deb_s = deb_r + DEB_W'(1);
            end
          end else begin
            deb_s   = '0;
            state_s = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (colum == '0) begin
            if (DEB_ONE) begin
              held_s  = 1'b0;
              row_s   = next_row(row_r);
              deb_s   = '0;
              state_s = ST_SCAN;
            end else begin
              deb_s   = DEB_W'(1);
              state_s = ST_DEB_REL;
            end
          end else begin
            state_s = ST_HELD;
          end
        end
        ST_DEB_REL: begin
          // Any column activity, single or multiple, means the key is still down.
          if (colum == '0) begin
            if (deb_r + DEB_W'(1) == DEB_W'(DEBOUNCE)) begin
              held_s  = 1'b0;
              row_s   = next_row(row_r);
              deb_s   = '0;
              state_s = ST_SCAN;
            end else begin
              deb_s = deb_r + DEB_W'(1);
            end
          end else begin
            deb_s   = '0;
            state_s = ST_HELD;
          end
        end
        default: begin
          deb_s   = '0;
          state_s = ST_SCAN;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM and output registers; disable aborts activity but keeps the last keycode.
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_SCAN;
      row_r     <= '0;
      col_r     <= '0;
      deb_r     <= '0;
      keycode_r <= '0;
      valid_r   <= 1'b0;
      held_r    <= 1'b0;
      merr_r    <= 1'b0;
    end else if (!enable) begin
      state_r   <= ST_SCAN;
      row_r     <= '0;
      col_r     <= '0;
      deb_r     <= '0;
      valid_r   <= 1'b0;
      held_r    <= 1'b0;
      merr_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      row_r     <= row_s;
      col_r     <= col_s;
      deb_r     <= deb_s;
      keycode_r <= keycode_s;
      valid_r   <= valid_s;
      held_r    <= held_s;
      merr_r    <= merr_s;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Randomised bench: a virtual key matrix drives the columns from the strobed row,
// and a tick-level behavioural model predicts every output each fin cycle.
module tb_keypad_scan_debounce;

  localparam int ROWS = 4, COLS = 3, DIV_W = 2, DEBOUNCE = 3, CODE_W = 4;
  localparam int N_CYC = 8000;

  logic              fin = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [COLS-1:0]   colum = '0;
  logic [ROWS-1:0]   scan;
  logic [CODE_W-1:0] keycode;
  logic              key_valid, key_held, multi_err;

  keypad_scan_debounce #(.ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .DEBOUNCE(DEBOUNCE)) dut (
    .fin(fin), .rst_n(rst_n), .enable(enable), .colum(colum), .scan(scan),
    .keycode(keycode), .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
  );

  always #5 fin = ~fin;

  // physical key matrix: keys[r][c] = key at row r, column c is down
  logic [COLS-1:0] keys [ROWS];

  int m_presc, m_row, m_streak, m_keycode;
  bit m_held, m_valid, m_merr;
  logic [COLS-1:0] m_cand;
  int n_checks = 0, n_fail = 0, n_press = 0, n_merr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_row = 0; m_streak = 0; m_keycode = 0;
    m_held = 0; m_valid = 0; m_merr = 0; m_cand = '0;
  endtask

  // One scan tick: m_streak counts consecutive qualifying ticks toward DEBOUNCE.
  task automatic model_tick(input logic [COLS-1:0] c);
    int idx;
    if (!m_held) begin
      if (m_streak == 0) begin
        if (c == '0) m_row = (m_row + 1) % ROWS;
        else if ($countones(c) > 1) begin m_merr = 1; n_merr++; end
        else begin m_cand = c; m_streak = 1; end
      end else if (c == m_cand) begin
        m_streak++;
        if (m_streak == DEBOUNCE) begin
          idx = 0;
          for (int i = 0; i < COLS; i++) if (m_cand[i]) idx = i;
          m_keycode = idx * ROWS + m_row;
          m_valid = 1; m_held = 1; m_streak = 0; n_press++;
        end
      end else m_streak = 0;
    end else begin
      if (c != '0) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == DEBOUNCE) begin
          m_held = 0; m_streak = 0; m_row = (m_row + 1) % ROWS;
        end
      end
    end
  endtask

  task automatic model_edge();
    m_valid = 0; m_merr = 0;
    if (!rst_n) model_reset();
    else if (!enable) begin
      m_presc = 0; m_row = 0; m_held = 0; m_streak = 0;
    end else if (m_presc == (1 << DIV_W) - 1) begin
      m_presc = 0;
      model_tick(colum);
    end else m_presc++;
  endtask

  task automatic check_outputs();
    check_eq("scan", scan, 1 << m_row);
    check_eq("keycode", keycode, m_keycode);
    check_eq("key_valid", key_valid, m_valid);
    check_eq("key_held", key_held, m_held);
    check_eq("multi_err", multi_err, m_merr);
  endtask

  initial begin
    int r, a, rr, cc, rst_left, en_left;
    rst_left = 0; en_left = 0;
    for (int i = 0; i < ROWS; i++) keys[i] = '0;
    model_reset();
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge fin);
      check_outputs();
      if (cyc == 3) begin
        rst_n = 1'b1; enable = 1'b1;
      end else if (cyc > 3) begin
        if (rst_left > 0) begin
          rst_left--;
          if (rst_left == 0) rst_n = 1'b1;
        end
        if (en_left > 0) begin
          en_left--;
          if (en_left == 0) enable = 1'b1;
        end
        r = $urandom_range(0, 999);
        if (r < 2 && rst_n && cyc > 400) begin
          rst_n = 1'b0;
          rst_left = $urandom_range(1, 4);
          #1;
          model_reset();
          check_eq("async_scan", scan, 1);
          check_eq("async_keycode", keycode, 0);
          check_eq("async_held", key_held, 0);
        end else if (r < 6 && enable && cyc > 400) begin
          enable = 1'b0;
          en_left = $urandom_range(1, 10);
        end else if (r < 50) begin
          a = $urandom_range(0, 9);
          rr = $urandom_range(0, ROWS - 1);
          cc = $urandom_range(0, COLS - 1);
          if (a < 4 || a < 8) for (int i = 0; i < ROWS; i++) keys[i] = '0;
          if (a >= 4) keys[rr][cc] = 1'b1;
        end
      end
      colum = keys[m_row];
      @(posedge fin);
      model_edge();
    end
    check_eq("presses_seen", n_press > 0, 1);
    check_eq("multi_seen", n_merr > 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
